// File: rtl/loader_pkg.sv
// Shared definitions for the program loaders: FSM state encoding and header length.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR0  = 3'd1,
        ST_HDR1  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } state_e;

    localparam int HDR_BYTES = 2;

    // States in which the loader owns the byte stream.
    function automatic logic is_busy_state(state_e s);
        return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_LOAD) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-store write bus of the program loader.
interface imem_loader_if #(parameter int ADDR_W = 10);
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              core_run;
    logic              busy;
    logic              error;

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata, core_run, busy, error
    );

    modport master (
        output start, in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata, core_run, busy, error
    );
endinterface

// File: rtl/loader_byte_counter.sv
// Loadable byte counter with terminal compare: o_last flags the byte that reaches i_target.
module loader_byte_counter #(
    parameter int CNT_W = 12,
    parameter int OUT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_target,
    output logic [OUT_W-1:0] o_addr,
    output logic             o_last
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_addr = r_count[OUT_W-1:0];
    assign o_last = ((r_count + ONE) == i_target);
endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program image into the instruction store, holding the core until done.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 2 ** (ADDR_W - 2)
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);
    localparam int CNT_W = ADDR_W + 2;

    state_e            r_state;
    state_e            w_state_next;
    state_e            w_after_payload;
    logic              r_busy;
    logic              r_mem_we;
    logic              r_core_run;
    logic              r_error;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic [15:0]       r_word_cnt;
    logic              w_accept;
    logic              w_load_accept;
    logic              w_start_ok;
    logic              w_cnt_last;
    logic [15:0]       w_hdr_n;
    logic [CNT_W-1:0]  w_target;
    logic [ADDR_W-1:0] w_cnt_addr;

    assign w_accept      = bus.in_valid && r_busy;
    assign w_load_accept = w_accept && (r_state == ST_LOAD);
    assign w_start_ok    = bus.start && !r_busy;
    assign w_hdr_n       = {r_word_cnt[15:8], bus.in_data};
    assign w_target      = {r_word_cnt[ADDR_W-1:0], 2'b00};

    loader_byte_counter #(.CNT_W(CNT_W), .OUT_W(ADDR_W)) u_counter (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_accept && (r_state == ST_HDR1)),
        .i_inc    (w_load_accept),
        .i_target (w_target),
        .o_addr   (w_cnt_addr),
        .o_last   (w_cnt_last)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       w_csum_ok;

    // Running XOR over header and payload; the checksum byte itself is excluded.
    always_ff @(posedge clk) begin
        if (reset || w_start_ok) begin
            r_csum <= 8'h00;
        end else if (w_accept && (r_state != ST_CSUM)) begin
            r_csum <= r_csum ^ bus.in_data;
        end
    end

    assign w_csum_ok       = (bus.in_data == r_csum);
    assign w_after_payload = ST_CSUM;
`else
    assign w_after_payload = ST_DONE;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (bus.start) w_state_next = ST_HDR0;
            end
            ST_HDR0: begin
                if (w_accept) w_state_next = ST_HDR1;
            end
            ST_HDR1: begin
                if (w_accept) begin
                    if ({16'd0, w_hdr_n} > 32'(MAX_WORDS)) w_state_next = ST_ERROR;
                    else if (w_hdr_n == 16'd0)            w_state_next = w_after_payload;
                    else                                   w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept && w_cnt_last) w_state_next = w_after_payload;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (w_accept) w_state_next = w_csum_ok ? ST_DONE : ST_ERROR;
            end
`endif
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state; core_run waits out the final write cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_core_run  <= 1'b0;
            r_error     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'h00;
            r_word_cnt  <= 16'h0000;
        end else begin
            r_state    <= w_state_next;
            r_busy     <= is_busy_state(w_state_next);
            r_error    <= (w_state_next == ST_ERROR);
            r_core_run <= (w_state_next == ST_DONE) && !w_load_accept;
            r_mem_we   <= w_load_accept;
            if (w_load_accept) begin
                r_mem_addr  <= w_cnt_addr;
                r_mem_wdata <= bus.in_data;
            end
            if (w_accept && (r_state == ST_HDR0)) r_word_cnt[15:8] <= bus.in_data;
            if (w_accept && (r_state == ST_HDR1)) r_word_cnt[7:0]  <= bus.in_data;
        end
    end

    assign bus.in_ready  = r_busy;
    assign bus.busy      = r_busy;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.core_run  = r_core_run;
    assign bus.error     = r_error;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: stream-index reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_imem_loader;
    import loader_pkg::*;

    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 2 ** (ADDR_W - 2);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks position in the stream and derives outputs from it.
    bit         m_active, m_done, m_err, m_we, m_rst;
    int         m_k, m_n, m_addr;
    logic [7:0] m_hi, m_data, m_csum;

    // Instruction store built from the write bus.
    logic [7:0] store [0:(2**ADDR_W)-1];
    int         we_count;
    int         last_we_addr;

    always @(posedge clk) begin
        if (bus.mem_we) begin
            store[bus.mem_addr] = bus.mem_wdata;
            we_count++;
            last_we_addr = int'(bus.mem_addr);
        end
        m_we = 1'b0;
        if (reset) begin
            m_active = 0; m_done = 0; m_err = 0; m_k = 0; m_n = 0; m_rst = 1;
        end else begin
            m_rst = 0;
            if (!m_active) begin
                if (bus.start) begin
                    m_active = 1; m_done = 0; m_err = 0; m_k = 0; m_csum = 8'h00;
                end
            end else if (bus.in_valid) begin
                if (m_k == 0) begin
                    m_hi = bus.in_data;
                end else if (m_k == 1) begin
                    m_n = int'({m_hi, bus.in_data});
                    if (m_n > MAX_WORDS) begin
                        m_err = 1; m_active = 0;
                    end else if (m_n == 0 && !CSUM_EN) begin
                        m_done = 1; m_active = 0;
                    end
                end else if (m_k < HDR_BYTES + 4 * m_n) begin
                    m_we = 1; m_addr = m_k - HDR_BYTES; m_data = bus.in_data;
                    if (m_k == HDR_BYTES + 4 * m_n - 1 && !CSUM_EN) begin
                        m_done = 1; m_active = 0;
                    end
                end else begin
                    if (bus.in_data == m_csum) m_done = 1;
                    else                       m_err = 1;
                    m_active = 0;
                end
                if (m_k < HDR_BYTES || m_k < HDR_BYTES + 4 * m_n) m_csum = m_csum ^ bus.in_data;
                m_k++;
            end
        end
    end

    always @(negedge clk) begin
        check("in_ready", 32'(bus.in_ready), 32'(m_active));
        check("busy",     32'(bus.busy),     32'(m_active));
        check("error",    32'(bus.error),    32'(m_err));
        check("core_run", 32'(bus.core_run), 32'(m_done && !m_we));
        check("mem_we",   32'(bus.mem_we),   32'(m_we));
        if (m_we) begin
            check("mem_addr",  32'(bus.mem_addr),  32'(m_addr));
            check("mem_wdata", 32'(bus.mem_wdata), 32'(m_data));
        end
        if (m_rst) begin
            check("rst_addr",  32'(bus.mem_addr),  32'd0);
            check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        end
    end

    logic [7:0] img [0:11] = '{8'hCA, 8'h0F, 8'h33, 8'h55, 8'h00, 8'h33,
                               8'h0F, 8'hFF, 8'h20, 8'h04, 8'h00, 8'h08};
    logic [7:0] stream [$];

    task automatic build_stream(input int n, input bit use_img, input bit bad_csum);
        logic [7:0] b, x;
        stream.delete();
        x = 8'h00;
        b = 8'(n >> 8); stream.push_back(b); x ^= b;
        b = 8'(n);      stream.push_back(b); x ^= b;
        if (n <= MAX_WORDS) begin
            for (int i = 0; i < 4 * n; i++) begin
                b = use_img ? img[i] : 8'($urandom);
                stream.push_back(b); x ^= b;
            end
            if (CSUM_EN) stream.push_back(bad_csum ? (x ^ 8'h01) : x);
        end
    endtask

    task automatic clear_store();
        for (int i = 0; i < 2 ** ADDR_W; i++) store[i] = 8'h00;
        we_count = 0;
        last_we_addr = -1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // mode 0: valid held high, 1: valid every other cycle, 2: random valid.
    // Returns after reset_after bytes (and a reset pulse) when reset_after >= 0.
    task automatic send_stream(input int mode, input int reset_after, input bit rand_start);
        int idx = 0;
        int budget = 40 * stream.size() + 100;
        bit pend = 0;
        bit v = 0;
        while (1) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (pend) idx++;
            if (idx >= stream.size() || (reset_after >= 0 && idx >= reset_after)) break;
            if (budget == 0) begin
                check("send_timeout", 32'(idx), 32'(stream.size()));
                break;
            end
            budget--;
            case (mode)
                0:       v = 1'b1;
                1:       v = ~v;
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            bus.in_valid = v;
            bus.in_data  = v ? stream[idx] : 8'($urandom);
            pend = v && bus.in_ready;
            if (rand_start && $urandom_range(0, 15) == 0) bus.start = 1'b1;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        if (reset_after >= 0 && idx >= reset_after) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end
    endtask

    task automatic settle();
        int budget = 200;
        while (bus.busy && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("idle_timeout", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_store(input int n);
        for (int i = 0; i < 4 * n; i++) check("store", 32'(store[i]), 32'(stream[HDR_BYTES + i]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, mode, rst_at;
        bit bad;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
        clear_store();
        repeat (3) @(negedge clk);
        check("reset_core_run", 32'(bus.core_run), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;

        // Three-word image, valid held high.
        clear_store(); build_stream(3, 1, 0);
        pulse_start(); send_stream(0, -1, 0); settle();
        check("t1_writes", 32'(we_count), 32'd12);
        check("t1_fetch0", {store[0], store[1], store[2], store[3]}, 32'hCA0F3355);
        check("t1_word2",  {store[8], store[9], store[10], store[11]}, 32'h20040008);
        check("t1_core_run", 32'(bus.core_run), 32'd1);
        $display("load n=3 valid-high writes=%0d", we_count);

        // Same image, valid toggling; restarted from DONE.
        clear_store(); build_stream(3, 1, 0);
        pulse_start(); send_stream(1, -1, 0); settle();
        check("t2_writes", 32'(we_count), 32'd12);
        check("t2_word1",  {store[4], store[5], store[6], store[7]}, 32'h00330FFF);
        $display("load n=3 valid-toggle writes=%0d", we_count);

        // Empty image.
        clear_store(); build_stream(0, 0, 0);
        pulse_start(); send_stream(0, -1, 0); settle();
        check("t3_writes", 32'(we_count), 32'd0);
        check("t3_core_run", 32'(bus.core_run), 32'd1);
        check("t3_busy", 32'(bus.busy), 32'd0);
        $display("load n=0 writes=%0d", we_count);

        // Oversized header.
        clear_store(); build_stream(MAX_WORDS + 1, 0, 0);
        pulse_start(); send_stream(0, -1, 0); settle();
        check("t4_error", 32'(bus.error), 32'd1);
        check("t4_in_ready", 32'(bus.in_ready), 32'd0);
        check("t4_core_run", 32'(bus.core_run), 32'd0);
        pulse_start();
        check("t4_restart_error", 32'(bus.error), 32'd0);
        check("t4_restart_busy", 32'(bus.busy), 32'd1);
        $display("load n=%0d error=%0d", MAX_WORDS + 1, bus.error);
        reset = 1'b1; @(negedge clk); reset = 1'b0;

        // Reset after five payload bytes, then a full reload.
        clear_store(); build_stream(3, 1, 0);
        pulse_start(); send_stream(0, HDR_BYTES + 5, 0);
        check("t5_rst_core_run", 32'(bus.core_run), 32'd0);
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        check("t5_rst_partial", 32'(we_count), 32'd5);
        clear_store();
        pulse_start(); send_stream(0, -1, 0); settle();
        check("t5_writes", 32'(we_count), 32'd12);
        check("t5_fetch0", {store[0], store[1], store[2], store[3]}, 32'hCA0F3355);
        $display("reset mid-load then reload writes=%0d", we_count);

        // Full store.
        clear_store(); build_stream(MAX_WORDS, 0, 0);
        pulse_start(); send_stream(0, -1, 0); settle();
        check("fill_writes", 32'(we_count), 32'(4 * MAX_WORDS));
        check("fill_last_addr", 32'(last_we_addr), 32'((2 ** ADDR_W) - 1));
        check_store(MAX_WORDS);
        $display("load n=%0d last_addr=%0d", MAX_WORDS, last_we_addr);

`ifdef IMEM_LOADER_CHECKSUM_EN
        clear_store();
        stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        pulse_start(); send_stream(0, -1, 0); settle();
        check("csum_ok_core_run", 32'(bus.core_run), 32'd1);
        check("csum_ok_error", 32'(bus.error), 32'd0);
        check("csum_ok_writes", 32'(we_count), 32'd4);
        $display("checksum 45 core_run=%0d", bus.core_run);
        stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h46};
        pulse_start(); send_stream(0, -1, 0); settle();
        check("csum_bad_error", 32'(bus.error), 32'd1);
        check("csum_bad_core_run", 32'(bus.core_run), 32'd0);
        $display("checksum 46 error=%0d", bus.error);
`endif

        // Randomized loads with stray starts and occasional resets.
        for (int t = 0; t < 40; t++) begin
            n    = ($urandom_range(0, 9) == 0) ? MAX_WORDS + 1 + $urandom_range(0, 3) : $urandom_range(0, 6);
            mode = $urandom_range(0, 2);
            bad  = ($urandom_range(0, 3) == 0);
            clear_store(); build_stream(n, 0, bad);
            rst_at = ($urandom_range(0, 5) == 0 && stream.size() > 1) ? $urandom_range(1, stream.size() - 1) : -1;
            pulse_start(); send_stream(mode, rst_at, 1); settle();
            if (rst_at < 0 && n <= MAX_WORDS) begin
                check("rand_writes", 32'(we_count), 32'(4 * n));
                check_store(n);
            end
            $display("random load n=%0d mode=%0d reset_at=%0d writes=%0d error=%0d",
                     n, mode, rst_at, we_count, bus.error);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
